// File: rtl/osr_unit_pkg.sv
// osr_unit shared types: FIFO status, OSR state, widths.
// Also holds the 5-bit "0 encodes 32" count decoder.
package osr_unit_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef struct packed {
    logic empty;
    logic full;
  } fifo_status;

  typedef enum logic {
    IDLE,
    LOAD
  } osr_state_e;

  function automatic logic [CNT_W-1:0] decode_n(
    input logic [4:0] v
  );
    return (v == 5'd0) ? 6'd32 : {1'b0, v};
  endfunction

endpackage

// File: rtl/osr_unit_if.sv
// TX FIFO read-side bundle between the FIFO and the OSR.
// master = OSR (pops), slave = FIFO (supplies data/flags).
interface osr_unit_if;
  import osr_unit_pkg::*;

  logic [DATA_W-1:0] fifo_data;
  fifo_status        fifo_st;
  logic              fifo_pop;

  modport master (
    output fifo_pop,
    input  fifo_data,
    input  fifo_st
  );

  modport slave (
    input  fifo_pop,
    output fifo_data,
    output fifo_st
  );

endinterface

// File: rtl/osr_unit_shifter.sv
// Combinational barrel shifter for OUT: 1..32 bits,
// left (MSB first) or right (LSB first).
module osr_shifter
  import osr_unit_pkg::*;
(
  input  logic [DATA_W-1:0] osr,
  input  logic [CNT_W-1:0]  n,
  input  logic              shift_right,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] osr_next
);

  logic [DATA_W-1:0] lo_mask;
  logic [CNT_W-1:0]  lsh;

  // n = 32 shifts everything out: mask all ones, next value zero
  assign lo_mask = ~({DATA_W{1'b1}} << n);
  assign lsh     = 6'd32 - n;

  always_comb begin
    out_data = '0;
    osr_next = '0;
    if (shift_right) begin
      out_data = osr & lo_mask;
      osr_next = osr >> n;
    end else begin
      out_data = osr >> lsh;
      osr_next = osr << n;
    end
  end

endmodule

// File: rtl/osr_unit.sv
// Output shift register for one PIO state machine.
// Pops the TX FIFO on PULL/autopull, shifts out on OUT.
module osr_unit
  import osr_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  osr_unit_if.master        fifo,
  input  logic              pull_req,
  input  logic              pull_block,
  input  logic              pull_ifempty,
  input  logic [DATA_W-1:0] x_reg,
  input  logic              out_req,
  input  logic [4:0]        out_count,
  input  logic              shift_right,
  input  logic              autopull_en,
  input  logic [4:0]        pull_thresh,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              stall,
  output logic [DATA_W-1:0] osr,
  output logic [CNT_W-1:0]  osr_count
);

  osr_state_e state_q;
  osr_state_e state_d;

  logic              pull_own_q;
  logic              pop;
  logic              exec;
  logic              xload;
  logic              have_data;
  logic              below_t;
  logic              refill;
  logic [CNT_W-1:0]  n;
  logic [CNT_W-1:0]  t;
  logic [CNT_W:0]    cnt_sum;
  logic [CNT_W-1:0]  cnt_sat;
  logic [DATA_W-1:0] sh_out;
  logic [DATA_W-1:0] sh_next;

  assign n         = decode_n(out_count);
  assign t         = decode_n(pull_thresh);
  assign below_t   = osr_count < t;
  assign refill    = autopull_en && !below_t;
  assign have_data = fifo.fifo_st.full || !fifo.fifo_st.empty;

  assign cnt_sum = {1'b0, osr_count} + {1'b0, n};
  assign cnt_sat = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[CNT_W-1:0];

  assign fifo.fifo_pop = pop;

  osr_shifter u_shifter (
    .osr         (osr),
    .n           (n),
    .shift_right (shift_right),
    .out_data    (sh_out),
    .osr_next    (sh_next)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    stall   = 1'b0;
    exec    = 1'b0;
    xload   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pull_req) begin
          // a simultaneous OUT loses and waits
          stall = out_req;
          if (!(pull_ifempty && below_t)) begin
            if (have_data) begin
              pop   = 1'b1;
              stall = 1'b1;
            end else if (pull_block) begin
              stall = 1'b1;
            end else begin
              xload = 1'b1;
            end
          end
        end else if (out_req) begin
          if (refill) begin
            stall = 1'b1;
            pop   = have_data;
          end else begin
            exec = 1'b1;
          end
        end else if (refill && have_data) begin
          pop = 1'b1;
        end
        if (pop) state_d = LOAD;
      end
      LOAD: begin
        state_d = IDLE;
        // the PULL that issued this pop completes here
        stall = out_req || (pull_req && !pull_own_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pull_own_q <= 1'b0;
      osr        <= '0;
      osr_count  <= 6'd32;
      out_data   <= '0;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pull_own_q <= pop && pull_req;
      out_valid  <= exec;
      if (state_q == LOAD) begin
        osr       <= fifo.fifo_data;
        osr_count <= '0;
      end else if (xload) begin
        osr       <= x_reg;
        osr_count <= '0;
      end else if (exec) begin
        osr       <= sh_next;
        osr_count <= cnt_sat;
        out_data  <= sh_out;
      end
    end
  end

endmodule
